// File: rtl/qsys_lcd_8080_fifo.sv
// Show-ahead synchronous FIFO that queues {rs, data} words for the 8080 writer.
// A push into a full FIFO is ignored, even when a pop happens in the same cycle.
module qsys_lcd_8080_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Aw    = 4,
  parameter int unsigned Width = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      level_o
);

  localparam logic [Aw:0] FullLevel = (Aw + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == FullLevel);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Full/empty are judged on the pre-pop state.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/qsys_lcd_8080_writer.sv
// Avalon-MM slave that queues command/data words and replays them as
// hardware-timed 8080 write cycles on a 16-bit LCD bus.
module qsys_lcd_8080_writer #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [3:0]  DEF_WR_LOW  = 4'd1,
  parameter logic [3:0]  DEF_WR_HIGH = 4'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_data
);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrCmd    = 2'd1;
  localparam logic [1:0] AddrStatus = 2'd2;
  localparam logic [1:0] AddrTiming = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StLow   = 2'd2,
    StHigh  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  timing_q, timing_d;
  logic        ovf_q, ovf_d;
  logic        cs_n_q, cs_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rs_q, rs_d;
  logic [15:0] data_q, data_d;

  logic            wr_en;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [16:0]     fifo_din, fifo_dout;
  logic [FIFO_AW:0] fifo_level;
  logic            busy;
  logic            unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  assign wr_en     = chipselect && !write_n;
  assign fifo_push = wr_en && ((address == AddrData) || (address == AddrCmd));
  assign fifo_din  = {(address == AddrData), writedata[15:0]};

  qsys_lcd_8080_fifo #(
    .Depth (FIFO_DEPTH),
    .Aw    (FIFO_AW),
    .Width (17)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    ovf_d    = ovf_q;
    timing_d = timing_q;
    if (fifo_push && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_en && (address == AddrStatus) && writedata[3]) begin
      ovf_d = 1'b0;
    end
    if (wr_en && (address == AddrTiming)) timing_d = writedata[7:0];
  end

  // Outputs are computed one cycle ahead so every LCD pin comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cs_n_d   = cs_n_q;
    wr_n_d   = wr_n_q;
    rs_d     = rs_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {rs_d, data_d} = fifo_dout;
          cs_n_d  = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        wr_n_d  = 1'b0;
        cnt_d   = timing_q[3:0];
        state_d = StLow;
      end
      StLow: begin
        if (cnt_q == 4'd0) begin
          wr_n_d  = 1'b1;
          cnt_d   = timing_q[7:4];
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHigh: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {rs_d, data_d} = fifo_dout;
          state_d = StSetup;
        end else begin
          cs_n_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      timing_q <= {DEF_WR_HIGH, DEF_WR_LOW};
      ovf_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rs_q     <= 1'b1;
      data_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timing_q <= timing_d;
      ovf_q    <= ovf_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
    end
  end

  assign busy = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    readdata = 32'h0;
    unique case (address)
      AddrStatus: readdata = {16'h0, 8'(fifo_level), 4'h0, ovf_q, busy, fifo_full, fifo_empty};
      AddrTiming: readdata = {24'h0, timing_q};
      default:    readdata = 32'h0;
    endcase
  end

  assign lcd_cs_n = cs_n_q;
  assign lcd_wr_n = wr_n_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_rd_n = 1'b1;

endmodule

// File: tb/tb_qsys_lcd_8080_writer.sv
// Scoreboard bench: words are queued as they are written and checked as they
// appear on the LCD bus, together with the WR low width of each transfer.
module tb_qsys_lcd_8080_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_data;

  always #5 clk = ~clk;

  qsys_lcd_8080_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_rs     (lcd_rs),
    .lcd_wr_n   (lcd_wr_n),
    .lcd_rd_n   (lcd_rd_n),
    .lcd_data   (lcd_data)
  );

  typedef struct packed {
    logic        rs;
    logic [15:0] data;
    logic [3:0]  low;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bus monitor
  logic        prev_wr = 1'b1, prev_cs = 1'b1;
  logic [16:0] cap;
  int          low_cnt, high_cnt, cs_cnt, last_high, last_cs_run;
  bit          in_high;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_wr  = 1'b1;
      prev_cs  = 1'b1;
      low_cnt  = 0;
      high_cnt = 0;
      cs_cnt   = 0;
      in_high  = 1'b0;
    end else begin
      if (!lcd_wr_n) begin
        if (prev_wr) begin
          in_high = 1'b0;
          cap     = {lcd_rs, lcd_data};
          low_cnt = 0;
        end
        low_cnt++;
      end else if (!prev_wr) begin
        check_eq("word_held", 32'({lcd_rs, lcd_data}), 32'(cap));
        if (exp_q.size() == 0) begin
          check_eq("sb_word_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("lcd_word", 32'(cap), 32'({mon_e.rs, mon_e.data}));
          check_eq("wr_low_cycles", 32'(low_cnt), 32'(mon_e.low) + 32'd1);
        end
        in_high  = 1'b1;
        high_cnt = 1;
      end else if (in_high) begin
        if (lcd_cs_n) begin
          last_high = high_cnt;
          in_high   = 1'b0;
        end else begin
          high_cnt++;
        end
      end
      if (!lcd_cs_n) begin
        cs_cnt++;
      end else if (!prev_cs) begin
        last_cs_run = cs_cnt;
        cs_cnt      = 0;
      end
      prev_wr = lcd_wr_n;
      prev_cs = lcd_cs_n;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push_word(input bit is_data, input logic [15:0] d, input logic [3:0] low,
                           input bit dropped);
    if (!dropped) exp_q.push_back({is_data, d, low});
    bus_write(is_data ? 2'd0 : 2'd1, {16'hDEAD, d});
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    address = 2'd2;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!readdata[2] && lcd_cs_n && exp_q.size() == 0) break;
    end
    check_eq("idle_reached", 32'({readdata[2], lcd_cs_n}), 32'b01);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr_low(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!lcd_wr_n) break;
    end
    check_eq("wr_low_seen", 32'(lcd_wr_n), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] rd;

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    check_eq("rst_wr_n", 32'(lcd_wr_n), 32'd1);
    check_eq("rst_rd_n", 32'(lcd_rd_n), 32'd1);
    check_eq("rst_rs", 32'(lcd_rs), 32'd1);
    check_eq("rst_data", 32'(lcd_data), 32'd0);
    bus_read(2'd2, rd);
    check_eq("rst_status", rd, 32'h0000_0001);
    bus_read(2'd3, rd);
    check_eq("rst_timing", rd, 32'h0000_0011);
    bus_read(2'd0, rd);
    check_eq("read_addr0", rd, 32'h0);

    // Command then data, back to back, cs held low across both
    bus_write(2'd3, 32'h11);
    push_word(1'b0, 16'h002C, 4'd1, 1'b0);
    push_word(1'b1, 16'hF800, 4'd1, 1'b0);
    wait_idle(100);
    check_eq("cs_run_two_words", 32'(last_cs_run), 32'd10);
    bus_read(2'd2, rd);
    check_eq("status_after_two", rd, 32'h0000_0001);

    // Single word, low 1 cycle / high 4 cycles, with write-to-strobe latency
    bus_write(2'd3, 32'h30);
    push_word(1'b1, 16'h1234, 4'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("setup_cs_n", 32'(lcd_cs_n), 32'd0);
    check_eq("setup_wr_n", 32'(lcd_wr_n), 32'd1);
    @(negedge clk);
    check_eq("latency_wr_n", 32'(lcd_wr_n), 32'd0);
    wait_idle(100);
    check_eq("high_hold_cycles", 32'(last_high), 32'd4);
    check_eq("cs_run_one_word", 32'(last_cs_run), 32'd6);

    // Overflow with the FSM stalled by the slowest timing
    bus_write(2'd3, 32'hFF);
    for (int i = 0; i < 18; i++) push_word(1'b1, 16'(16'hA000 + i), 4'd15, i >= 17);
    bus_read(2'd2, rd);
    check_eq("status_full_ovf", rd, 32'h0000_100E);
    bus_write(2'd2, 32'h8);
    bus_read(2'd2, rd);
    check_eq("status_ovf_clr", rd, 32'h0000_1006);
    wait_idle(1000);
    bus_read(2'd2, rd);
    check_eq("status_after_ovf", rd, 32'h0000_0001);

    // Timing change during LOW applies only from the next counter load
    bus_write(2'd3, 32'h22);
    push_word(1'b1, 16'h5555, 4'd2, 1'b0);
    push_word(1'b0, 16'h0AAA, 4'd5, 1'b0);
    wait_wr_low(20);
    bus_write(2'd3, 32'h05);
    wait_idle(100);
    bus_read(2'd3, rd);
    check_eq("timing_readback", rd, 32'h0000_0005);

    // Asynchronous reset in the middle of LOW
    bus_write(2'd3, 32'hFF);
    push_word(1'b1, 16'h0101, 4'd15, 1'b0);
    push_word(1'b1, 16'h0202, 4'd15, 1'b0);
    push_word(1'b1, 16'h0303, 4'd15, 1'b0);
    wait_wr_low(20);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_wr_n", 32'(lcd_wr_n), 32'd1);
    check_eq("async_cs_n", 32'(lcd_cs_n), 32'd1);
    exp_q.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus_read(2'd2, rd);
    check_eq("post_rst_status", rd, 32'h0000_0001);
    bus_read(2'd3, rd);
    check_eq("post_rst_timing", rd, 32'h0000_0011);
    check_eq("post_rst_data", 32'({lcd_rs, lcd_data}), 32'h1_0000);
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", 32'({lcd_cs_n, lcd_wr_n}), 32'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
